// File: rtl/opsg_pkg.sv
// Shared encodings and default constants for the OPSG noise channel.
package opsg_pkg;

   typedef enum logic [1:0] {
      NF_DIV0  = 2'd0,
      NF_DIV1  = 2'd1,
      NF_DIV2  = 2'd2,
      NF_TONE3 = 2'd3
   } nf_e;

   typedef enum logic {
      FB_PERIODIC = 1'b0,
      FB_WHITE    = 1'b1
   } fb_e;

   // Field order matches the wr_data bus: {fb, nf[1:0]}
   typedef struct packed {
      fb_e fb;
      nf_e nf;
   } ctrl_t;

   localparam int DEF_DIV0 = 16;
   localparam int DEF_DIV1 = 32;
   localparam int DEF_DIV2 = 64;

endpackage

// File: rtl/opsg_lfsr.sv
// Noise shift register: white/periodic feedback, seed load and all-zero guard.
module opsg_lfsr #(
   parameter int                    LFSR_WIDTH = 16,
   parameter int                    TAP_A      = 0,
   parameter int                    TAP_B      = 3,
   parameter logic [LFSR_WIDTH-1:0] SEED       = {1'b1, {(LFSR_WIDTH-1){1'b0}}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  shift_en,
   input  logic                  white,
   output logic [LFSR_WIDTH-1:0] lfsr
);

   logic [LFSR_WIDTH-1:0] lfsr_q;
   logic [LFSR_WIDTH-1:0] lfsr_d;
   logic [LFSR_WIDTH-1:0] shifted;
   logic                  fb;

   always_comb begin
      fb      = white ? (lfsr_q[TAP_A] ^ lfsr_q[TAP_B]) : lfsr_q[0];
      shifted = {fb, lfsr_q[LFSR_WIDTH-1:1]};
      lfsr_d  = lfsr_q;
      if (load) begin
         lfsr_d = SEED;
      end else if (shift_en) begin
         // A stuck-at-zero register would silence the channel forever
         lfsr_d = (shifted == '0) ? SEED : shifted;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= SEED;
      else     lfsr_q <= lfsr_d;
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/opsg_noise_gen.sv
// OPSG noise channel: divider/phase logic driving an LFSR shift per phase rise.
// Optional debug ports (lfsr_state, shift_count) are enabled by OPSG_NOISE_DEBUG_EN.
module opsg_noise_gen
   import opsg_pkg::*;
#(
   parameter int                    LFSR_WIDTH = 16,
   parameter int                    TAP_A      = 0,
   parameter int                    TAP_B      = 3,
   parameter logic [LFSR_WIDTH-1:0] SEED       = {1'b1, {(LFSR_WIDTH-1){1'b0}}},
   parameter int                    CNT_WIDTH  = 10,
   parameter int                    DIV0       = DEF_DIV0,
   parameter int                    DIV1       = DEF_DIV1,
   parameter int                    DIV2       = DEF_DIV2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_en,
   input  logic                  wr,
   input  logic [2:0]            wr_data,
   input  logic                  tone3_pulse,
   output logic                  noise_bit,
   output logic                  shift_pulse
`ifdef OPSG_NOISE_DEBUG_EN
   ,
   output logic [LFSR_WIDTH-1:0] lfsr_state,
   output logic [15:0]           shift_count
`endif
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // Truncate to the counter width; a zero reload means toggle every tick
   function automatic logic [CNT_WIDTH-1:0] fix_reload(input int div);
      logic [CNT_WIDTH-1:0] t;
      t = CNT_WIDTH'(div);
      return (t == '0) ? CNT_ONE : t;
   endfunction

   localparam logic [CNT_WIDTH-1:0] RELOAD0 = fix_reload(DIV0);
   localparam logic [CNT_WIDTH-1:0] RELOAD1 = fix_reload(DIV1);
   localparam logic [CNT_WIDTH-1:0] RELOAD2 = fix_reload(DIV2);

   ctrl_t                 ctrl_q, ctrl_d;
   logic [CNT_WIDTH-1:0]  counter_q, counter_d;
   logic                  phase_q, phase_d;
   logic                  shift_pulse_q, shift_pulse_d;
   logic [CNT_WIDTH-1:0]  reload_sel;
   logic                  shift;
   logic [LFSR_WIDTH-1:0] lfsr_val;

   always_comb begin
      case (ctrl_q.nf)
         NF_DIV0: reload_sel = RELOAD0;
         NF_DIV1: reload_sel = RELOAD1;
         default: reload_sel = RELOAD2;
      endcase
   end

   always_comb begin
      ctrl_d    = ctrl_q;
      counter_d = counter_q;
      phase_d   = phase_q;
      if (wr) begin
         ctrl_d    = ctrl_t'(wr_data);
         counter_d = CNT_ONE;
         phase_d   = 1'b0;
      end else if (clk_en) begin
         if (ctrl_q.nf == NF_TONE3) begin
            if (tone3_pulse) phase_d = ~phase_q;
         end else if (counter_q == CNT_ONE) begin
            counter_d = reload_sel;
            phase_d   = ~phase_q;
         end else begin
            counter_d = counter_q - CNT_ONE;
         end
      end
      // A write forces phase low, so it can never coincide with a shift
      shift         = ~phase_q & phase_d;
      shift_pulse_d = shift;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q        <= ctrl_t'(3'b000);
         counter_q     <= CNT_ONE;
         phase_q       <= 1'b0;
         shift_pulse_q <= 1'b0;
      end else begin
         ctrl_q        <= ctrl_d;
         counter_q     <= counter_d;
         phase_q       <= phase_d;
         shift_pulse_q <= shift_pulse_d;
      end
   end

   opsg_lfsr #(
      .LFSR_WIDTH (LFSR_WIDTH),
      .TAP_A      (TAP_A),
      .TAP_B      (TAP_B),
      .SEED       (SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .load     (wr),
      .shift_en (shift),
      .white    (ctrl_q.fb == FB_WHITE),
      .lfsr     (lfsr_val)
   );

   assign noise_bit   = lfsr_val[0];
   assign shift_pulse = shift_pulse_q;

`ifdef OPSG_NOISE_DEBUG_EN
   logic [15:0] shift_count_q, shift_count_d;

   always_comb begin
      shift_count_d = shift_count_q;
      if (wr)         shift_count_d = 16'd0;
      else if (shift) shift_count_d = shift_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) shift_count_q <= 16'd0;
      else     shift_count_q <= shift_count_d;
   end

   assign lfsr_state  = lfsr_val;
   assign shift_count = shift_count_q;
`endif

endmodule
